// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises Rx, finds the start edge, samples each bit at
// mid-bit and presents the byte with a one-cycle valid strobe or a frame error pulse.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line (line must be known good)
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling eight data bits LSB first, one per bit period
// STOP  | sampling the stop bit and deciding valid byte vs. framing error
module uart_rx #(
    parameter int BAUD_DIV    = 5208,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_TC = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic                   line_ok_q, line_ok_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   start_det;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign start_det = (state_q == IDLE) && line_ok_q && rx_prev_q && !rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], Rx};
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            line_ok_q <= 1'b1;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_ok_q <= line_ok_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        line_ok_d = line_ok_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // After a framing error the line must be seen high before a new start counts.
                if (!line_ok_q && rx_s) line_ok_d = 1'b1;
                if (start_det) begin
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == HALF_TC) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_q == FULL_TC) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_q == FULL_TC) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        line_ok_d = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    // The detect cycle already belongs to the frame, so busy rises with it.
    assign busy       = (state_q != IDLE) || start_det;

endmodule
